mux64_serial_scan_ctrl: RTL and testbench
=========================================

Name: mux64_serial_scan_ctrl

Overview:
- Controller that sequences the select input of a mux_64x1_using_8x1 instance to serialize a 64-bit word one bit per handshake.
- Captures a word plus a length, then steps the 6-bit select through the requested bit range, LSB-first or MSB-first.
- Each mux output bit is presented on a valid/ready serial stream.
- Sits between a parallel producer, such as a register file or FIFO, and a 1-bit serial link or shifter.

Parameters:
- MSB_FIRST, default 0: 0 = select steps up from 0 to len; 1 = select steps down from len to 0.
- CNT_W, default 16: width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- load_valid  in  1  producer offers a word
- load_ready  out  1  controller accepts a word (IDLE only)
- load_data  in  64  word to serialize; drives the mux a input via a holding register
- load_len  in  6  last bit index; a frame carries load_len+1 bits (1..64)
- abort  in  1  cancels the current frame
- ser_valid  out  1  ser_bit is valid
- ser_ready  in  1  consumer accepts ser_bit
- ser_bit  out  1  mux y output
- ser_last  out  1  current beat is the final bit of the frame
- sel  out  6  current mux select, exposed for debug
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last beat is accepted
- frame_cnt  out  CNT_W  number of completed frames, wraps at the maximum

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; data_q=0; len_q=0; sel=0; frame_done=0; frame_cnt=0.
  - After reset: load_ready=1, ser_valid=0, busy=0, ser_last=0.
  - Reset mid-frame drops the frame with no done pulse and no count.
- Datapath:
  - data_q (64b) drives the mux a input; sel drives the mux s input.
  - ser_bit = mux y, i.e. data_q[sel], combinational from registers.
  - Zero-latency from sel to ser_bit.
- State IDLE:
  - load_ready=1, ser_valid=0, busy=0.
  - On load_valid&load_ready: data_q<=load_data, len_q<=load_len.
  - Start select: sel<=0 if MSB_FIRST=0, else sel<=load_len. Go to SEND.
  - First beat is presented the cycle after the load handshake.
- State SEND:
  - busy=1, load_ready=0, ser_valid=!abort.
  - End index: end_idx = len_q if MSB_FIRST=0, else 0.
  - ser_last = (sel==end_idx) && ser_valid.
- Beat accept (ser_valid&ser_ready):
  - If sel != end_idx: sel steps by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1). Stay in SEND.
  - If sel == end_idx: go to IDLE, frame_done<=1 for one cycle, frame_cnt<=frame_cnt+1 (mod 2^CNT_W). sel holds its last value.
- Stall: with ser_valid=1 and ser_ready=0, sel, ser_bit and ser_last hold stable until accepted. No beat is ever dropped or repeated.
- abort in SEND:
  - ser_valid is forced 0 that cycle, so a simultaneous ser_ready is not a transfer.
  - Next state is IDLE; no frame_done pulse; frame_cnt unchanged.
  - abort in IDLE is ignored.
- load_len=0 gives a single-beat frame: ser_last=1 on the first beat.
- load_len=63 gives a 64-beat frame; sel covers 0..63 without wrap.
- Select never wraps past 0 or 63; the end_idx compare ends the frame first.
- Back-to-back frames: load_ready is low throughout SEND, so the earliest next load is the cycle after the last beat. Minimum gap is one idle cycle.
- load_data/load_len are ignored outside the load handshake; data_q is stable for the whole frame.
- Priority in one cycle: rst_n > abort > beat accept.

Test Plan:
- Reset then LSB-first frame: rst_n low 2 cycles; check load_ready=1, frame_cnt=0. Load 64'hA5, len=7 with ser_ready=1.
  - Expect ser_bit sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles; sel 0..7.
  - ser_last only on sel=7; frame_done pulse next cycle; frame_cnt=1.
- Single-hot sweep: for indices 0,1,7,36,38,60,63, load a with only bit i set and len=i.
  - Expect exactly one ser_bit=1, on the final beat with ser_last=1.
  - Expect i+1 beats per frame; ser_bit=0 on all other beats.
- MSB_FIRST=1: load 64'h8000_0000_0000_0001, len=63.
  - Expect sel 63 down to 0, first bit 1, last bit 1, 62 zeros between.
  - ser_last at sel=0.
- Backpressure: len=3, ser_ready toggling 1,0,0,1,0,1,1.
  - Expect sel/ser_bit stable during low ready; exactly 4 accepted beats in order; no drops or duplicates.
- Abort: len=15, assert abort together with ser_ready=1 at beat 5.
  - Expect ser_valid=0 that cycle, IDLE next cycle, no frame_done, frame_cnt unchanged.
  - A new load is accepted immediately after.
- Reset mid-frame and wrap: pull rst_n low during beat 10; expect IDLE, outputs at reset values, frame_cnt=0.
  - Separately, with CNT_W=2, run 5 frames; expect frame_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/mux64_serial_scan_ctrl.sv
// Serializes a captured 64-bit word by stepping the select of a 64:1 mux (built as an 8x1 tree)
// through bits 0..len (or len..0), presenting each bit on a valid/ready stream.
module mux64_serial_scan_ctrl #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [63:0]      load_data,
  input  logic [5:0]       load_len,
  input  logic             abort,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic [5:0]       sel,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [63:0]      data_q;
  logic [5:0]       len_q;
  logic [5:0]       sel_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [5:0]       end_idx;
  logic [7:0]       stage;
  logic             beat_acc;

  assign end_idx    = MSB_FIRST ? 6'd0 : len_q;
  assign busy       = (state_q == StSend);
  assign load_ready = (state_q == StIdle);
  // abort masks valid so a coincident ready is never a transfer
  assign ser_valid  = busy && !abort;
  assign ser_last   = ser_valid && (sel_q == end_idx);
  assign beat_acc   = ser_valid && ser_ready;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Two-level 8x1 mux tree: low select bits pick within each octet, high bits pick the octet.
  always_comb begin
    stage = '0;
    for (int g = 0; g < 8; g++) begin
      stage[g] = data_q[{3'(g), sel_q[2:0]}];
    end
    ser_bit = stage[sel_q[5:3]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      data_q       <= '0;
      len_q        <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_valid) begin
            data_q  <= load_data;
            len_q   <= load_len;
            sel_q   <= MSB_FIRST ? load_len : 6'd0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (beat_acc) begin
            if (sel_q == end_idx) begin
              state_q      <= StIdle;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
            end else begin
              sel_q <= MSB_FIRST ? (sel_q - 6'd1) : (sel_q + 6'd1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux64_serial_scan_ctrl.sv
// Scoreboard bench: an LSB-first/16-bit-counter DUT and an MSB-first/2-bit-counter DUT run in
// lockstep on shared stimulus; a negedge monitor checks each DUT against its own expected queue.
module tb_mux64_serial_scan_ctrl;

  typedef struct packed {
    logic       bit_v;
    logic       last;
    logic [5:0] sel;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_data = '0;
  logic [5:0]  load_len = '0;
  logic        abort = 1'b0;
  logic        ser_ready = 1'b0;

  logic [1:0]  lr, sv, sb, sl, bz, fd;
  logic [5:0]  sel0, sel1;
  logic [15:0] fc0;
  logic [1:0]  fc1;

  mux64_serial_scan_ctrl #(.MSB_FIRST(1'b0), .CNT_W(16)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[0]),
    .load_data(load_data), .load_len(load_len), .abort(abort), .ser_valid(sv[0]),
    .ser_ready(ser_ready), .ser_bit(sb[0]), .ser_last(sl[0]), .sel(sel0), .busy(bz[0]),
    .frame_done(fd[0]), .frame_cnt(fc0)
  );

  mux64_serial_scan_ctrl #(.MSB_FIRST(1'b1), .CNT_W(2)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[1]),
    .load_data(load_data), .load_len(load_len), .abort(abort), .ser_valid(sv[1]),
    .ser_ready(ser_ready), .ser_bit(sb[1]), .ser_last(sl[1]), .sel(sel1), .busy(bz[1]),
    .frame_done(fd[1]), .frame_cnt(fc1)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    exp_cnt[2] = '{0, 0};
  bit    pend[2] = '{1'b0, 1'b0};
  bit    pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int    idx[7] = '{0, 1, 7, 36, 38, 60, 63};

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qclear();
    q0.delete();
    q1.delete();
  endtask

  // Reference: frame of len+1 bits, LSB-first for dut0, MSB-first for dut1.
  task automatic push_frame(input logic [63:0] w, input int len);
    for (int i = 0; i <= len; i++) begin
      q0.push_back('{bit_v: w[i], last: (i == len), sel: 6'(i)});
      q1.push_back('{bit_v: w[len - i], last: (i == len), sel: 6'(len - i)});
    end
  endtask

  task automatic check_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk("rst_load_ready", d, 64'(lr[d]), 64'd1);
      chk("rst_ser_valid", d, 64'(sv[d]), 64'd0);
      chk("rst_busy", d, 64'(bz[d]), 64'd0);
      chk("rst_ser_last", d, 64'(sl[d]), 64'd0);
      chk("rst_frame_done", d, 64'(fd[d]), 64'd0);
      chk("rst_frame_cnt", d, (d == 0) ? 64'(fc0) : 64'(fc1), 64'd0);
      chk("rst_sel", d, (d == 0) ? 64'(sel0) : 64'(sel1), 64'd0);
    end
  endtask

  // Monitor: compares presented beats with the queue head, pops on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        beat_t       e;
        logic [63:0] cnt_act;
        int          mask;
        cnt_act = (d == 0) ? 64'(fc0) : 64'(fc1);
        mask    = (d == 0) ? 32'hFFFF : 32'h3;
        chk("frame_done", d, 64'(fd[d]), 64'(pend[d]));
        pend[d] = 1'b0;
        chk("frame_cnt", d, cnt_act, 64'(exp_cnt[d]));
        if (abort) chk("valid_during_abort", d, 64'(sv[d]), 64'd0);
        if (!sv[d]) begin
          if (sl[d]) chk("last_without_valid", d, 64'(sl[d]), 64'd0);
        end else if (qsize(d) == 0) begin
          chk("unexpected_beat", d, 64'(sv[d]), 64'd0);
        end else begin
          e = qfront(d);
          chk("beat", d, {56'd0, sb[d], sl[d], (d == 0) ? sel0 : sel1}, 64'(e));
          if (ser_ready) begin
            qpop(d);
            if (e.last) begin
              pend[d]    = 1'b1;
              exp_cnt[d] = (exp_cnt[d] + 1) & mask;
            end
          end
        end
      end
    end
  end

  // kind: 0 normal, 1 abort at beat `at`, 2 reset at beat `at`.
  // mode: 0 ready high, 1 random ready, 2 fixed toggle pattern.
  task automatic run_frame(input logic [63:0] w, input int len, input int mode, input int kind,
                           input int at);
    int   cnt, beats, cyc, k;
    logic rdy, acc;
    cnt = 0;
    while (lr[0] !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("load_ready_wait", 0, 64'(lr[0]), 64'd1);
    load_valid = 1'b1;
    load_data  = w;
    load_len   = 6'(len);
    push_frame(w, len);
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = {$urandom, $urandom};
    load_len   = 6'($urandom);
    beats = 0;
    cyc   = 0;
    k     = 0;
    while (bz[0] === 1'b1 && cyc < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[k % 7];
      endcase
      k++;
      if (kind == 1 && beats == at) begin
        abort     = 1'b1;
        ser_ready = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        ser_ready = 1'b0;
        qclear();
        chk("idle_after_abort", 0, 64'(lr[0]), 64'd1);
        chk("idle_after_abort", 1, 64'(lr[1]), 64'd1);
        return;
      end
      if (kind == 2 && beats == at) begin
        rst_n     = 1'b0;
        ser_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        qclear();
        exp_cnt = '{0, 0};
        pend    = '{1'b0, 1'b0};
        check_reset_vals();
        rst_n = 1'b1;
        return;
      end
      ser_ready = rdy;
      acc = sv[0] && rdy;
      @(posedge clk); #1;
      if (acc) beats++;
      cyc++;
    end
    ser_ready = 1'b0;
    chk("frame_timeout", 0, 64'(cyc < 1000), 64'd1);
    @(posedge clk); #1;
    chk("beats_left", 0, 64'(q0.size()), 64'd0);
    chk("beats_left", 1, 64'(q1.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(64'hA5, 7, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      run_frame(64'd1 << idx[i], idx[i], i % 2, 0, 0);
    end
    run_frame(64'h8000_0000_0000_0001, 63, 0, 0, 0);
    run_frame({$urandom, $urandom}, 3, 2, 0, 0);
    run_frame({$urandom, $urandom}, 15, 0, 1, 5);
    run_frame({$urandom, $urandom}, $urandom_range(0, 63), 1, 0, 0);
    run_frame({$urandom, $urandom}, 20, 1, 2, 10);
    repeat (5) run_frame({$urandom, $urandom}, $urandom_range(0, 10), 1, 0, 0);
    repeat (6) run_frame({$urandom, $urandom}, $urandom_range(0, 63), 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
